// File: rtl/grf.sv
`default_nettype none
// ============================================================================
// Module   : grf
// Purpose  : 32 x 32-bit general register file. It has two combinational read
//            ports that forward the pending write, one synchronous write port,
//            and a commit trace with a saturating commit counter.
// Ports    : clk, reset (sync, active-high)
//            WE/A3/WD   - write enable, address, data
//            A1/A2      - read addresses, RD1/RD2 read data
//            PC         - PC of the writing instruction (trace only)
//            trace_*    - last committed write (valid for one cycle)
//            write_count- committed writes since reset, saturating
// Revision : 1.0 - initial release
// ============================================================================
module grf (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [4:0]  A3,
    input  logic [31:0] WD,
    input  logic [31:0] PC,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_addr,
    output logic [31:0] trace_data,
    output logic [31:0] write_count
);

    localparam int          NUM_REGS  = 32;
    localparam logic [4:0]  c_ZERO_REG = 5'd0;
    localparam logic [31:0] c_CNT_MAX  = 32'hFFFF_FFFF;

    logic [31:0] r_regs [0:NUM_REGS-1];
    logic        r_trace_valid;
    logic [31:0] r_trace_pc;
    logic [4:0]  r_trace_addr;
    logic [31:0] r_trace_data;
    logic [31:0] r_write_count;

    logic        w_wr_active;
    logic        w_commit;
    logic [31:0] w_write_count_nxt;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;

    // A write to register 0 is a no-op everywhere: it is not stored, traced,
    // counted or forwarded. Forwarding ignores reset because it only reflects
    // the value on the write bus, not a state change.
    always_comb begin
        w_wr_active = WE && (A3 != c_ZERO_REG);
        w_commit    = w_wr_active && !reset;
    end

    // Read ports: register 0 is hard-wired to zero, then the pending write is
    // forwarded ahead of the stored value.
    always_comb begin
        w_rd1 = r_regs[A1];
        if (A1 == c_ZERO_REG) begin
            w_rd1 = 32'd0;
        end else if (w_wr_active && (A3 == A1)) begin
            w_rd1 = WD;
        end

        w_rd2 = r_regs[A2];
        if (A2 == c_ZERO_REG) begin
            w_rd2 = 32'd0;
        end else if (w_wr_active && (A3 == A2)) begin
            w_rd2 = WD;
        end
    end

    // The counter sticks at all-ones instead of wrapping.
    always_comb begin
        w_write_count_nxt = r_write_count;
        if (w_commit && (r_write_count != c_CNT_MAX)) begin
            w_write_count_nxt = r_write_count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_commit) begin
            r_regs[A3] <= WD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_trace_valid <= 1'b0;
            r_trace_pc    <= 32'd0;
            r_trace_addr  <= 5'd0;
            r_trace_data  <= 32'd0;
            r_write_count <= 32'd0;
        end else begin
            r_trace_valid <= w_commit;
            r_write_count <= w_write_count_nxt;
            if (w_commit) begin
                r_trace_pc   <= PC;
                r_trace_addr <= A3;
                r_trace_data <= WD;
            end
        end
    end

    assign RD1         = w_rd1;
    assign RD2         = w_rd2;
    assign trace_valid = r_trace_valid;
    assign trace_pc    = r_trace_pc;
    assign trace_addr  = r_trace_addr;
    assign trace_data  = r_trace_data;
    assign write_count = r_write_count;

endmodule
`default_nettype wire

// File: tb/tb_grf.sv
`default_nettype none
// ============================================================================
// Module   : tb_grf
// Purpose  : Directed self-checking bench for grf. Inputs change on the falling
//            edge, and outputs are checked 1 ns later, away from the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grf;

    logic        clk;
    logic        reset;
    logic        WE;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [31:0] PC;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic [31:0] write_count;

    int n_cmp = 0;
    int n_err = 0;

    grf dut (
        .clk         (clk),
        .reset       (reset),
        .WE          (WE),
        .A1          (A1),
        .A2          (A2),
        .A3          (A3),
        .WD          (WD),
        .PC          (PC),
        .RD1         (RD1),
        .RD2         (RD2),
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data),
        .write_count (write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step through one rising edge and return on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; WE = 1'b0; A1 = 5'd0; A2 = 5'd0; A3 = 5'd0;
        WD = 32'd0; PC = 32'd0;
        @(negedge clk);
        tick();

        // Reset state
        reset = 1'b0; A1 = 5'd5; A2 = 5'd31;
        #1;
        chk("rst_rd1",   RD1, 32'd0);
        chk("rst_rd2",   RD2, 32'd0);
        chk("rst_tv",    {31'd0, trace_valid}, 32'd0);
        chk("rst_tpc",   trace_pc, 32'd0);
        chk("rst_count", write_count, 32'd0);

        // First write: reg5 <= 12345678 at PC 3000
        WE = 1'b1; A3 = 5'd5; WD = 32'h1234_5678; PC = 32'h0000_3000;
        #1;
        chk("w5_bypass_rd1", RD1, 32'h1234_5678);
        tick();
        WE = 1'b0; WD = 32'hDEAD_BEEF;
        #1;
        chk("w5_rd1",   RD1, 32'h1234_5678);
        chk("w5_tv",    {31'd0, trace_valid}, 32'd1);
        chk("w5_tpc",   trace_pc, 32'h0000_3000);
        chk("w5_taddr", {27'd0, trace_addr}, 32'd5);
        chk("w5_tdata", trace_data, 32'h1234_5678);
        chk("w5_count", write_count, 32'd1);

        // Write to reg0 is ignored, both before and after the edge
        WE = 1'b1; A3 = 5'd0; WD = 32'hFFFF_FFFF; PC = 32'h0000_3004; A1 = 5'd0;
        #1;
        chk("w0_rd1_pre", RD1, 32'd0);
        tick();
        #1;
        chk("w0_rd1_post", RD1, 32'd0);
        chk("w0_tv",       {31'd0, trace_valid}, 32'd0);
        chk("w0_count",    write_count, 32'd1);
        chk("w0_taddr",    {27'd0, trace_addr}, 32'd5);
        WE = 1'b0;

        // reg8 <= 7, then 9 is forwarded on both ports while it is pending
        WE = 1'b1; A3 = 5'd8; WD = 32'd7; PC = 32'h0000_3008;
        tick();
        WD = 32'd9; PC = 32'h0000_300C; A1 = 5'd8; A2 = 5'd8;
        #1;
        chk("byp_rd1",   RD1, 32'd9);
        chk("byp_rd2",   RD2, 32'd9);
        chk("byp_count", write_count, 32'd2);
        A1 = 5'd5;
        #1;
        chk("byp_rd1_other", RD1, 32'h1234_5678);
        chk("byp_rd2_only",  RD2, 32'd9);
        WE = 1'b0;
        #1;
        chk("stored8_rd2", RD2, 32'd7);
        WE = 1'b1;
        tick();
        WE = 1'b0; A1 = 5'd8;
        #1;
        chk("after9_rd1",  RD1, 32'd9);
        chk("after9_count", write_count, 32'd3);

        // Mid-run reset, then back-to-back writes to regs 1, 2 and 31
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_rd1",   RD1, 32'd0);
        chk("mid_rst_count", write_count, 32'd0);
        WE = 1'b1; A3 = 5'd1; WD = 32'h0000_0011; PC = 32'h0000_4000;
        tick();
        A3 = 5'd2; WD = 32'h0000_0022; PC = 32'h0000_4004;
        #1;
        chk("b2b1_tv",    {31'd0, trace_valid}, 32'd1);
        chk("b2b1_taddr", {27'd0, trace_addr}, 32'd1);
        tick();
        A3 = 5'd31; WD = 32'h0000_3131; PC = 32'h0000_4008;
        #1;
        chk("b2b2_tv",    {31'd0, trace_valid}, 32'd1);
        chk("b2b2_taddr", {27'd0, trace_addr}, 32'd2);
        tick();
        WE = 1'b0; A1 = 5'd1; A2 = 5'd31;
        #1;
        chk("b2b3_tv",    {31'd0, trace_valid}, 32'd1);
        chk("b2b3_taddr", {27'd0, trace_addr}, 32'd31);
        chk("b2b3_tdata", trace_data, 32'h0000_3131);
        chk("b2b3_tpc",   trace_pc, 32'h0000_4008);
        chk("b2b3_count", write_count, 32'd3);
        chk("b2b_reg1",   RD1, 32'h0000_0011);
        chk("b2b_reg31",  RD2, 32'h0000_3131);
        tick();
        #1;
        chk("idle_tv",    {31'd0, trace_valid}, 32'd0);
        chk("idle_taddr", {27'd0, trace_addr}, 32'd31);

        // Reset together with a write: forwarding stays, the write is dropped
        reset = 1'b1; WE = 1'b1; A3 = 5'd4; WD = 32'd1; A1 = 5'd4;
        #1;
        chk("rstwr_bypass", RD1, 32'd1);
        tick();
        reset = 1'b0; WE = 1'b0;
        #1;
        chk("rstwr_reg4",  RD1, 32'd0);
        chk("rstwr_reg31", RD2, 32'd0);
        chk("rstwr_tv",    {31'd0, trace_valid}, 32'd0);
        chk("rstwr_count", write_count, 32'd0);

        // Counter saturation
        force dut.r_write_count = 32'hFFFF_FFFD;
        #1;
        release dut.r_write_count;
        #1;
        chk("sat_preload", write_count, 32'hFFFF_FFFD);
        WE = 1'b1; A3 = 5'd3; WD = 32'd3; PC = 32'h0000_5000;
        tick();
        #1;
        chk("sat_1", write_count, 32'hFFFF_FFFE);
        tick();
        #1;
        chk("sat_2", write_count, 32'hFFFF_FFFF);
        tick();
        #1;
        chk("sat_3", write_count, 32'hFFFF_FFFF);
        WE = 1'b0;
        tick();
        #1;
        chk("sat_hold", write_count, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/grf.md
GRF -- requirements
Module: grf

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port WE, input, 1 bit: register write enable from the controller.
REQ-005 Port A1, input, 5 bits: read-port-1 address (rs).
REQ-006 Port A2, input, 5 bits: read-port-2 address (rt).
REQ-007 Port A3, input, 5 bits: write address (rt, rd, or 31), as selected by the RegDst mux.
REQ-008 Port WD, input, 32 bits: write data (ALU result, DM result, or PC+4), as selected by the Memback mux.
REQ-009 Port PC, input, 32 bits: PC of the writing instruction; used only for the trace outputs.
REQ-010 Port RD1, output, 32 bits: read data 1.
REQ-011 Port RD2, output, 32 bits: read data 2.
REQ-012 Port trace_valid, output, 1 bit: a committed write occurred at the previous edge.
REQ-013 Port trace_pc, output, 32 bits: PC of that committed write.
REQ-014 Port trace_addr, output, 5 bits: register number of that committed write.
REQ-015 Port trace_data, output, 32 bits: data of that committed write.
REQ-016 Port write_count, output, 32 bits: number of committed writes since reset.

Function
REQ-017 The block SHALL hold 32 registers of 32 bits each, indexed 0-31.
REQ-018 Register 0 SHALL always read 0; a write with A3=0 SHALL NOT change any storage.
REQ-019 A committed write is defined as: rising edge with reset=0, WE=1 and A3!=0.
REQ-020 On a committed write, reg[A3] SHALL take WD at that edge.
REQ-021 RD1 and RD2 SHALL be combinational functions of A1/A2 and the stored registers, with zero-cycle latency.
REQ-022 Bypass on port 1: when WE=1, A3!=0 and A3==A1, RD1 SHALL equal WD (the value about to be written), not the stored value.
REQ-023 Bypass on port 2: the rule of REQ-022 SHALL apply identically to RD2 with A2.
REQ-024 When A1==A2, both read ports SHALL return identical values, including under bypass.
REQ-025 trace_valid SHALL be a registered signal: 1 for exactly the cycle after each committed write, otherwise 0.
REQ-026 trace_pc, trace_addr and trace_data SHALL capture PC, A3 and WD at each committed write, and hold their values when no write commits.
REQ-027 A write with WE=1 and A3=0 SHALL leave trace_valid=0 and SHALL NOT increment write_count.
REQ-028 write_count SHALL increment by 1 per committed write and saturate at 32'hFFFFFFFF, never wrapping to 0.
REQ-029 Back-to-back committed writes on consecutive edges SHALL each be traced; trace_valid SHALL stay 1 across them.

Reset
REQ-030 On an edge with reset=1, all 32 registers SHALL become 0.
REQ-031 On an edge with reset=1, trace_valid, trace_pc, trace_addr, trace_data and write_count SHALL all become 0.
REQ-032 Reset SHALL have priority over WE: a write requested in a reset cycle SHALL be dropped and SHALL NOT be counted.
REQ-033 Bypass (REQ-022, REQ-023) SHALL remain active during a reset cycle; only state updates are suppressed.
REQ-034 The block SHALL accept a reset mid-run; all state SHALL be 0 on the following cycle.

Verification
REQ-035 The bench SHALL cover: reset, then WE=1, A3=5, WD=32'h1234_5678, PC=32'h3000 -> the next cycle shows RD1=32'h1234_5678 with A1=5, trace_valid=1, trace_pc=32'h3000, trace_addr=5, write_count=1.
REQ-036 The bench SHALL cover: WE=1, A3=0, WD=32'hFFFF_FFFF -> RD1=0 with A1=0, both during and after the edge; trace_valid=0; write_count unchanged.
REQ-037 The bench SHALL cover: reg 8 holds 7; WE=1, A3=8, WD=9, A1=A2=8 in the same cycle -> RD1=RD2=9 before the edge.
REQ-038 The bench SHALL cover: writes on 3 consecutive edges to regs 1, 2, 31 -> trace_valid=1 for 3 cycles, trace_addr sequence 1, 2, 31, write_count=3.
REQ-039 The bench SHALL cover: reset=1 together with WE=1, A3=4, WD=1 -> after the edge, reg 4=0, trace_valid=0, write_count=0.
REQ-040 The bench SHALL cover: write_count forced near 32'hFFFFFFFE, then 3 committed writes -> write_count ends at 32'hFFFFFFFF.
